// File: rtl/process_scheduler.sv
// Round-robin process table with a retired-instruction quantum counter and context-switch PC delivery.
// Optional per-slot retired-instruction statistics are compiled in when SCHED_STATS_EN is defined.
module process_scheduler #(
   parameter int NUM_PROC = 4,
   parameter int PID_W    = 2,
   parameter int PC_W     = 32,
   parameter int QUANTUM  = 16,
   parameter int CNT_W    = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_we,
   input  logic [PID_W-1:0] load_pid,
   input  logic [PC_W-1:0]  load_pc,
   input  logic             start,
   input  logic             step,
   input  logic [PC_W-1:0]  pc_atual,
   input  logic             io_req,
   input  logic             fim_req,
   input  logic             io_done,
   input  logic [PID_W-1:0] io_done_pid,
   output logic             troca_contexto,
   output logic [PC_W-1:0]  pc_novo,
   output logic [PID_W-1:0] processo_atual,
   output logic             ocioso,
   output logic             todos_fim
`ifdef SCHED_STATS_EN
   ,
   input  logic [PID_W-1:0] stat_pid,
   output logic [31:0]      stat_count
`endif
);

   typedef enum logic [1:0] {SL_EMPTY, SL_READY, SL_BLOCKED, SL_FINISHED} slot_t;
   typedef enum logic [2:0] {S_IDLE, S_SELECT, S_SWITCH, S_RUN, S_WAIT, S_DONE} state_t;

   state_t              r_state;
   slot_t               r_slot [NUM_PROC];
   logic [PC_W-1:0]     r_pc   [NUM_PROC];
   logic [CNT_W-1:0]    r_cnt;
   logic                r_started;

   logic [NUM_PROC-1:0] w_wake;
   logic [NUM_PROC-1:0] w_ready;
   logic [NUM_PROC-1:0] w_blocked;
   int                  w_base;
   logic                w_found;
   logic [PID_W-1:0]    w_sel;
   logic [PC_W-1:0]     w_sel_pc;
   logic                w_run_step;
   logic                w_expire;
   logic [PC_W-1:0]     w_pc_next;

   // A same-cycle io_done already counts as READY for the search and for leaving WAIT.
   always_comb begin
      for (int i = 0; i < NUM_PROC; i++) begin
         w_wake[i]    = io_done && (io_done_pid == PID_W'(i)) && (r_slot[i] == SL_BLOCKED);
         w_ready[i]   = (r_slot[i] == SL_READY) || w_wake[i];
         w_blocked[i] = (r_slot[i] == SL_BLOCKED) && !w_wake[i];
      end
   end

   always_comb begin
      w_base  = r_started ? ((int'(processo_atual) + 1) % NUM_PROC) : 0;
      w_found = 1'b0;
      w_sel   = '0;
      for (int k = 0; k < NUM_PROC; k++) begin
         for (int j = 0; j < NUM_PROC; j++) begin
            if (!w_found && w_ready[j] && (((w_base + k) % NUM_PROC) == j)) begin
               w_found = 1'b1;
               w_sel   = PID_W'(j);
            end
         end
      end
   end

   assign w_sel_pc   = r_pc[w_sel];
   assign w_run_step = (r_state == S_RUN) && step;
   assign w_expire   = (r_cnt == CNT_W'(QUANTUM - 1));
   assign w_pc_next  = pc_atual + PC_W'(1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state        <= S_IDLE;
         r_cnt          <= '0;
         r_started      <= 1'b0;
         troca_contexto <= 1'b0;
         pc_novo        <= '0;
         processo_atual <= '0;
         ocioso         <= 1'b0;
         todos_fim      <= 1'b0;
         for (int i = 0; i < NUM_PROC; i++) begin
            r_slot[i] <= SL_EMPTY;
            r_pc[i]   <= '0;
         end
      end else begin
         troca_contexto <= 1'b0;
         // Later assignments win: a block of the running slot overrides an io_done for it.
         for (int i = 0; i < NUM_PROC; i++) begin
            if (w_wake[i])
               r_slot[i] <= SL_READY;
            if ((r_state == S_IDLE) && load_we && (load_pid == PID_W'(i))) begin
               r_slot[i] <= SL_READY;
               r_pc[i]   <= load_pc;
            end
            if (w_run_step && (processo_atual == PID_W'(i))) begin
               if (fim_req) begin
                  r_slot[i] <= SL_FINISHED;
               end else if (io_req) begin
                  r_slot[i] <= SL_BLOCKED;
                  r_pc[i]   <= w_pc_next;
               end else if (w_expire) begin
                  r_pc[i]   <= w_pc_next;
               end
            end
         end

         case (r_state)
            S_IDLE: begin
               if (start && (|w_ready))
                  r_state <= S_SELECT;
            end
            S_SELECT: begin
               if (w_found) begin
                  processo_atual <= w_sel;
                  pc_novo        <= w_sel_pc;
                  troca_contexto <= 1'b1;
                  r_started      <= 1'b1;
                  r_state        <= S_SWITCH;
               end else if (|w_blocked) begin
                  ocioso  <= 1'b1;
                  r_state <= S_WAIT;
               end else begin
                  todos_fim <= 1'b1;
                  r_state   <= S_DONE;
               end
            end
            S_SWITCH: begin
               r_cnt   <= '0;
               r_state <= S_RUN;
            end
            S_RUN: begin
               if (step) begin
                  if (fim_req || io_req || w_expire)
                     r_state <= S_SELECT;
                  else
                     r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_WAIT: begin
               if (|w_wake) begin
                  ocioso  <= 1'b0;
                  r_state <= S_SELECT;
               end
            end
            S_DONE:  r_state <= S_DONE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef SCHED_STATS_EN
   logic [31:0] r_stat [NUM_PROC];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_PROC; i++)
            r_stat[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_PROC; i++) begin
            if (w_run_step && (processo_atual == PID_W'(i)) && (r_stat[i] != 32'hFFFF_FFFF))
               r_stat[i] <= r_stat[i] + 32'd1;
         end
      end
   end

   always_comb begin
      stat_count = '0;
      for (int i = 0; i < NUM_PROC; i++) begin
         if (stat_pid == PID_W'(i))
            stat_count = r_stat[i];
      end
   end
`endif

endmodule

// File: tb/tb_process_scheduler.sv
// Bench for process_scheduler: directed scenarios plus randomized runs against a slot-table reference model.
`timescale 1ns/1ps
module tb_process_scheduler;
   localparam int NP    = 4;
   localparam int PID_W = 2;
   localparam int PC_W  = 32;
   localparam int Q     = 4;
   localparam int CNT_W = 8;
   localparam int EMP = 0, RDY = 1, BLK = 2, FIN = 3;

   logic             clock = 1'b0;
   logic             reset;
   logic             load_we;
   logic [PID_W-1:0] load_pid;
   logic [PC_W-1:0]  load_pc;
   logic             start;
   logic             step;
   logic [PC_W-1:0]  pc_atual;
   logic             io_req;
   logic             fim_req;
   logic             io_done;
   logic [PID_W-1:0] io_done_pid;
   logic             troca_contexto;
   logic [PC_W-1:0]  pc_novo;
   logic [PID_W-1:0] processo_atual;
   logic             ocioso;
   logic             todos_fim;
`ifdef SCHED_STATS_EN
   logic [PID_W-1:0] stat_pid;
   logic [31:0]      stat_count;
`endif

   process_scheduler #(.NUM_PROC(NP), .PID_W(PID_W), .PC_W(PC_W), .QUANTUM(Q), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset), .load_we(load_we), .load_pid(load_pid), .load_pc(load_pc),
      .start(start), .step(step), .pc_atual(pc_atual), .io_req(io_req), .fim_req(fim_req),
      .io_done(io_done), .io_done_pid(io_done_pid), .troca_contexto(troca_contexto),
      .pc_novo(pc_novo), .processo_atual(processo_atual), .ocioso(ocioso), .todos_fim(todos_fim)
`ifdef SCHED_STATS_EN
      , .stat_pid(stat_pid), .stat_count(stat_count)
`endif
   );

   always #5 clock = ~clock;

   // Reference model: per-slot state and saved PC, running pid, PC of the running process.
   int          m_st [NP];
   logic [31:0] m_pc [NP];
   int          m_cur;
   bit          m_started;
   logic [31:0] m_run_pc;

   int n_chk, n_fail;
   int res, mask, kind, n, dp, da, runs, p;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NP; i++) begin
         m_st[i] = EMP;
         m_pc[i] = '0;
      end
      m_cur = 0;
      m_started = 1'b0;
      m_run_pc = '0;
   endtask

   function automatic int m_search();
      int base;
      int j;
      base = m_started ? (m_cur + 1) % NP : 0;
      for (int k = 0; k < NP; k++) begin
         j = (base + k) % NP;
         if (m_st[j] == RDY) return j;
      end
      return -1;
   endfunction

   task automatic load(input int pid, input logic [31:0] pc);
      load_we = 1'b1; load_pid = 2'(pid); load_pc = pc;
      tick();
      load_we = 1'b0;
      m_st[pid] = RDY;
      m_pc[pid] = pc;
   endtask

   task automatic check_zero_outputs(input string tag);
      check_eq({tag, "_troca"}, 32'(troca_contexto), 0);
      check_eq({tag, "_pc_novo"}, pc_novo, 0);
      check_eq({tag, "_pid"}, 32'(processo_atual), 0);
      check_eq({tag, "_ocioso"}, 32'(ocioso), 0);
      check_eq({tag, "_todos_fim"}, 32'(todos_fim), 0);
   endtask

   // Called right after the edge that triggered a selection; follows SELECT and its outcome.
   task automatic resolve(output int r);
      int  sel;
      bit  anyb;
      check_eq("select_troca", 32'(troca_contexto), 0);
      check_eq("select_ocioso", 32'(ocioso), 0);
      sel = m_search();
      anyb = 1'b0;
      for (int i = 0; i < NP; i++) if (m_st[i] == BLK) anyb = 1'b1;
      tick();
      if (sel >= 0) begin
         check_eq("switch_pulse", 32'(troca_contexto), 1);
         check_eq("switch_pc", pc_novo, m_pc[sel]);
         check_eq("switch_pid", 32'(processo_atual), sel);
         m_cur = sel;
         m_started = 1'b1;
         m_run_pc = m_pc[sel];
         tick();
         check_eq("switch_one_cycle", 32'(troca_contexto), 0);
         r = 0;
      end else if (anyb) begin
         check_eq("wait_ocioso", 32'(ocioso), 1);
         check_eq("wait_troca", 32'(troca_contexto), 0);
         r = 1;
      end else begin
         check_eq("done_todos_fim", 32'(todos_fim), 1);
         check_eq("done_troca", 32'(troca_contexto), 0);
         r = 2;
      end
   endtask

   // One complete run: n retired instructions, the last carries fim/io, else n must equal Q.
   task automatic run_proc(input int nst, input bit fim, input bit io, input int dpid, input int dat);
      bit hit;
      check_eq("run_pid", 32'(processo_atual), m_cur);
      for (int s = 0; s < nst; s++) begin
         repeat ($urandom_range(0, 2)) begin
            step = 1'b0;
            fim_req = 1'($urandom_range(0, 1));
            io_req = 1'($urandom_range(0, 1));
            pc_atual = $urandom;
            tick();
         end
         step = 1'b1;
         pc_atual = m_run_pc;
         fim_req = (s == nst - 1) && fim;
         io_req = (s == nst - 1) && io;
         hit = 1'b0;
         if (dpid >= 0 && s == dat) begin
            io_done = 1'b1;
            io_done_pid = 2'(dpid);
            hit = (m_st[dpid] == BLK);
         end
         tick();
         step = 1'b0; fim_req = 1'b0; io_req = 1'b0; io_done = 1'b0;
         m_run_pc = m_run_pc + 32'd1;
         if (hit) m_st[dpid] = RDY;
      end
      if (fim) begin
         m_st[m_cur] = FIN;
      end else if (io) begin
         m_st[m_cur] = BLK;
         m_pc[m_cur] = m_run_pc;
      end else begin
         m_pc[m_cur] = m_run_pc;
      end
   endtask

   // Issued while the scheduler waits; only a BLOCKED pid releases it.
   task automatic wake(input int pid, output int r);
      bit hit;
      hit = (m_st[pid] == BLK);
      io_done = 1'b1;
      io_done_pid = 2'(pid);
      tick();
      io_done = 1'b0;
      if (hit) begin
         m_st[pid] = RDY;
         resolve(r);
      end else begin
         r = 1;
         check_eq("wait_keep_ocioso", 32'(ocioso), 1);
         check_eq("wait_keep_troca", 32'(troca_contexto), 0);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: observed no completion, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_chk = 0; n_fail = 0;
      reset = 1'b0; load_we = 1'b0; load_pid = '0; load_pc = '0; start = 1'b0; step = 1'b0;
      pc_atual = '0; io_req = 1'b0; fim_req = 1'b0; io_done = 1'b0; io_done_pid = '0;
`ifdef SCHED_STATS_EN
      stat_pid = '0;
`endif
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check_zero_outputs("reset");
      #2 reset = 1'b1;
      tick();

      // start with an empty table is ignored
      start = 1'b1; tick(); start = 1'b0;
      repeat (3) tick();
      check_eq("empty_start_troca", 32'(troca_contexto), 0);
      check_eq("empty_start_ocioso", 32'(ocioso), 0);
      check_eq("empty_start_fim", 32'(todos_fim), 0);

      load(0, 32'd50); load(0, 32'd100); load(1, 32'd300); load(2, 32'd600);
      start = 1'b1; tick(); start = 1'b0;
      resolve(res);                              // pid0 @100
      run_proc(Q, 0, 0, -1, 0); resolve(res);   // pid1 @300
      run_proc(3, 0, 1, -1, 0); resolve(res);   // pid1 blocks at 302, pid2 @600
      run_proc(Q, 0, 0, -1, 0); resolve(res);   // pid0 @104
      run_proc(Q, 0, 0, -1, 0); resolve(res);   // pid1 skipped, pid2 @604
      run_proc(Q, 0, 0, 1, 1);  resolve(res);   // pid1 woken, pid0 @108
      run_proc(Q, 0, 0, -1, 0); resolve(res);   // pid1 resumes @303
      run_proc(2, 0, 1, 1, 1);  resolve(res);   // same-cycle io_done loses to the block
      run_proc(1, 0, 1, -1, 0); resolve(res);
      run_proc(Q, 0, 1, -1, 0); resolve(res);   // everyone blocked
      repeat (3) begin
         tick();
         check_eq("idle_ocioso", 32'(ocioso), 1);
         check_eq("idle_troca", 32'(troca_contexto), 0);
      end
      wake(3, res);                              // empty slot ignored
      wake(2, res);
      run_proc(Q, 1, 1, -1, 0); resolve(res);   // fim+io at quantum end: finished
      wake(2, res);                              // finished pid ignored
      wake(0, res);
      run_proc(1, 1, 0, -1, 0); resolve(res);
      wake(1, res);
      run_proc(2, 1, 0, -1, 0); resolve(res);   // all finished

      for (int c = 0; c < 4; c++) begin
         start = 1'b1; step = 1'b1; load_we = 1'b1; load_pid = 2'(c); load_pc = 32'd9;
         io_done = 1'b1; io_done_pid = 2'(c); fim_req = 1'b1; io_req = 1'b1;
         tick();
         check_eq("done_hold_fim", 32'(todos_fim), 1);
         check_eq("done_hold_troca", 32'(troca_contexto), 0);
         check_eq("done_hold_pid", 32'(processo_atual), m_cur);
      end
      start = 1'b0; step = 1'b0; load_we = 1'b0; io_done = 1'b0; fim_req = 1'b0; io_req = 1'b0;

      // asynchronous reset out of DONE, then during a SWITCH pulse
      #2 reset = 1'b0;
      #1 check_zero_outputs("rst_done");
      #2 reset = 1'b1;
      model_reset();
      tick();
      load(3, 32'd7);
      start = 1'b1; tick(); start = 1'b0;
      tick();
      check_eq("pre_rst_troca", 32'(troca_contexto), 1);
      check_eq("pre_rst_pc", pc_novo, 32'd7);
      #2 reset = 1'b0;
      #1 check_zero_outputs("rst_switch");
      #2 reset = 1'b1;
      model_reset();
      tick();
      start = 1'b1; tick(); start = 1'b0;
      repeat (3) tick();
      check_eq("post_rst_start_troca", 32'(troca_contexto), 0);
      check_eq("post_rst_start_ocioso", 32'(ocioso), 0);

      // randomized scheduling sessions
      for (int trial = 0; trial < 3; trial++) begin
         mask = int'($urandom_range(1, 15));
         for (int i = 0; i < NP; i++) begin
            if (((mask >> i) & 1) == 1)
               load(i, (trial == 1) ? (32'hFFFF_FFFD - 32'(i)) : $urandom);
         end
         start = 1'b1; tick(); start = 1'b0;
         resolve(res);
         runs = 0;
         while (res != 2 && runs < 200) begin
            if (res == 1) begin
               p = int'($urandom_range(0, NP - 1));
               wake(p, res);
            end else begin
               kind = int'($urandom_range(0, 7));
               n = int'($urandom_range(1, Q));
               dp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NP - 1)) : -1;
               da = int'($urandom_range(0, n - 1));
               if (kind < 2 || runs > 40)
                  run_proc(n, 1, 1'($urandom_range(0, 1)), dp, da);
               else if (kind < 4)
                  run_proc(n, 0, 1, dp, da);
               else
                  run_proc(Q, 0, 0, dp, int'($urandom_range(0, Q - 1)));
               resolve(res);
            end
            runs++;
         end
         check_eq("rand_session_done", 32'(todos_fim), 1);
         reset = 1'b0;
         #3 check_eq("rand_rst_fim", 32'(todos_fim), 0);
         #2 reset = 1'b1;
         model_reset();
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
